// File: rtl/sync_fifo_param.sv
`timescale 1ns/1ps
// Single-clock parametrised FIFO with fill count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable registered or fall-through read port.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept decisions use the flags as they stood before the edge, so a
  // write into a full FIFO is refused even if a read frees a slot this cycle.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // A new error at the same edge as a clear must survive the clear.
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wdata;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;
      logic             rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q    <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem[rd_ptr_q];
        end
      end

      assign rdata    = rdata_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
      // Zero the head while empty so stale or unwritten storage never shows.
      assign rdata    = empty ? '0 : mem[rd_ptr_q];
      assign rd_valid = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
`timescale 1ns/1ps
// Scoreboard bench for sync_fifo_param: a registered-read instance carries most of the
// directed sequence, a fall-through instance covers the FWFT head/pop behaviour.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;

  logic       wr_en0, rd_en0, clr_err0;
  logic [7:0] wdata0, rdata0;
  logic       rd_valid0, full0, empty0, almost_full0, almost_empty0, overflow0, underflow0;
  logic [4:0] count0;

  logic       wr_en1, rd_en1, clr_err1;
  logic [7:0] wdata1, rdata1;
  logic       rd_valid1, full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [4:0] count1;

  int checks = 0;
  int errors = 0;

  logic [7:0] expQ0[$];
  logic [7:0] expQ1[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wdata(wdata0), .rd_en(rd_en0), .clr_err(clr_err0),
    .rdata(rdata0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(almost_full0), .almost_empty(almost_empty0), .count(count0),
    .overflow(overflow0), .underflow(underflow0)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wdata(wdata1), .rd_en(rd_en1), .clr_err(clr_err1),
    .rdata(rdata1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(almost_full1), .almost_empty(almost_empty1), .count(count1),
    .overflow(overflow1), .underflow(underflow1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus on the registered-read instance and return 1ns after the edge.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en0   = w;
    wdata0   = d;
    rd_en0   = r;
    clr_err0 = c;
    @(posedge clk);
    #1;
  endtask

  // Registered-read monitor: every cycle with rd_valid consumes one expected word.
  always @(negedge clk) begin
    if (!rst && rd_valid0) begin
      if (expQ0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb0_unexpected: actual rd_valid=1 rdata=0x%0h required no read at %0t", rdata0, $time);
      end else begin
        checkOutput("sb0_rdata", 32'(rdata0), 32'(expQ0.pop_front()));
      end
    end
  end

  // Fall-through monitor: the head word is consumed when it is valid and popped.
  always @(negedge clk) begin
    if (!rst && rd_valid1 && rd_en1) begin
      if (expQ1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb1_unexpected: actual pop of 0x%0h required none at %0t", rdata1, $time);
      end else begin
        checkOutput("sb1_rdata", 32'(rdata1), 32'(expQ1.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    wr_en0 = 0; rd_en0 = 0; clr_err0 = 0; wdata0 = '0;
    wr_en1 = 0; rd_en1 = 0; clr_err1 = 0; wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_count", 32'(count0), 0);
    checkOutput("rst_empty", 32'(empty0), 1);
    checkOutput("rst_full", 32'(full0), 0);
    checkOutput("rst_afull", 32'(almost_full0), 0);
    checkOutput("rst_aempty", 32'(almost_empty0), 1);
    checkOutput("rst_ovf", 32'(overflow0), 0);
    checkOutput("rst_unf", 32'(underflow0), 0);
    checkOutput("rst_rdvalid", 32'(rd_valid0), 0);
    checkOutput("rst_rdata", 32'(rdata0), 0);
    checkOutput("rst_fwft_valid", 32'(rd_valid1), 0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count0), 32'(i));
      checkOutput("fill_afull", 32'(almost_full0), 32'(i >= 12));
      checkOutput("fill_aempty", 32'(almost_empty0), 32'(i <= 4));
    end
    checkOutput("fill_full", 32'(full0), 1);

    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("ovf_set", 32'(overflow0), 1);
    checkOutput("ovf_count", 32'(count0), 16);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      expQ0.push_back(8'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_count", 32'(count0), 32'(16 - i));
    end
    checkOutput("drain_empty", 32'(empty0), 1);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf_set", 32'(underflow0), 1);
    checkOutput("unf_rdvalid", 32'(rd_valid0), 0);
    checkOutput("unf_rdata_hold", 32'(rdata0), 32'h10);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(overflow0), 0);
    checkOutput("clr_unf", 32'(underflow0), 0);

    // Refill with 0x30..0x3F, then clear together with a write while full
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
    checkOutput("clr_vs_ovf", 32'(overflow0), 1);
    checkOutput("clr_vs_ovf_count", 32'(count0), 16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_after", 32'(overflow0), 0);

    for (int i = 0; i < 8; i++) begin
      expQ0.push_back(8'(8'h30 + i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("half_count", 32'(count0), 8);

    // Simultaneous read/write with pointer wrap; 0x38..0x3F come out first
    for (int k = 0; k < 40; k++) begin
      expQ0.push_back(k < 8 ? 8'(8'h38 + k) : 8'(8'h80 + k - 8));
      applyStimulus(1'b1, 8'(8'h80 + k), 1'b1, 1'b0);
      checkOutput("rw_count", 32'(count0), 8);
    end

    expQ0.push_back(8'hA0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(count0), 7);
    checkOutput("pre_rst_rdata", 32'(rdata0), 32'hA0);

    // Asynchronous reset mid-burst, observed before the next edge
    wr_en0 = 1'b1;
    wdata0 = 8'hEE;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_count", 32'(count0), 0);
    checkOutput("arst_empty", 32'(empty0), 1);
    checkOutput("arst_full", 32'(full0), 0);
    checkOutput("arst_afull", 32'(almost_full0), 0);
    checkOutput("arst_aempty", 32'(almost_empty0), 1);
    checkOutput("arst_rdvalid", 32'(rd_valid0), 0);
    checkOutput("arst_rdata", 32'(rdata0), 0);
    wr_en0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("arst_unf", 32'(underflow0), 1);
    checkOutput("arst_unf_rdvalid", 32'(rd_valid0), 0);
    checkOutput("arst_unf_count", 32'(count0), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Fall-through head visibility and pop
    wr_en1 = 1'b1;
    wdata1 = 8'h5A;
    expQ1.push_back(8'h5A);
    @(posedge clk);
    #1;
    wr_en1 = 1'b0;
    checkOutput("fwft_rdata", 32'(rdata1), 32'h5A);
    checkOutput("fwft_valid", 32'(rd_valid1), 1);
    checkOutput("fwft_count", 32'(count1), 1);
    rd_en1 = 1'b1;
    @(posedge clk);
    #1;
    rd_en1 = 1'b0;
    checkOutput("fwft_pop_empty", 32'(empty1), 1);
    checkOutput("fwft_pop_valid", 32'(rd_valid1), 0);
    @(posedge clk);
    #1;

    checkOutput("sb0_drained", 32'(expQ0.size()), 0);
    checkOutput("sb1_drained", 32'(expQ1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
